sumador_acumulador_sat: RTL

- Parametrised, streaming successor of the combinational saturating adder.
- Accumulates frames of LEN signed W-bit samples. Each sample is added to or subtracted from a running sum with per-step saturation.
- Emits one saturated result per frame through a valid/ready handshake, with a sticky saturation flag.
- Sits between the filter product stage and the output register, replacing chains of combinational adders.

---
 rtl/sumador_acumulador_sat_if.sv | 29 ++
 rtl/sumador_acumulador_sat.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sumador_acumulador_sat_if.sv
// Streaming sample/result bus for the saturating frame accumulator.
// The slave side is the accumulator. The master side is the environment that
// supplies samples and collects frame results.
interface sumador_acumulador_sat_if #(
    parameter int W   = 22,
    parameter int LEN = 4
);
    localparam int CW = $clog2(LEN + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  din;
    logic                 sub;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  dout;
    logic                 sat_flag;
    logic [CW-1:0]        count;

    modport slave (
        input  in_valid, din, sub, out_ready,
        output in_ready, out_valid, dout, sat_flag, count
    );

    modport master (
        output in_valid, din, sub, out_ready,
        input  in_ready, out_valid, dout, sat_flag, count
    );
endinterface

// File: rtl/sumador_acumulador_sat.sv
// Saturating frame accumulator.
// It adds or subtracts LEN signed samples into a running sum. Each step is
// clamped to [MIN_LIM, MAX_LIM]. It then offers the frame result over a
// valid/ready handshake, together with a sticky flag that records whether any
// step clamped.
module sumador_acumulador_sat #(
    parameter int W        = 22,
    parameter int LEN      = 4,
    parameter int HEADROOM = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    sumador_acumulador_sat_if.slave   bus
);
    localparam int CW = $clog2(LEN + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(LEN);

    // The limits are held in the width of the exact sum, so both comparisons
    // are plain signed compares with no risk of wrap.
    localparam logic signed [W+1:0] LIM_ONE = (W+2)'(1);
    localparam logic signed [W+1:0] MAX_LIM = (LIM_ONE <<< (W - 1 - HEADROOM)) - LIM_ONE;
    localparam logic signed [W+1:0] MIN_LIM = -(LIM_ONE <<< (W - 1 - HEADROOM));

    typedef enum logic {
        ST_ACC,
        ST_DONE
    } state_e;

    state_e               state_q, state_d;
    logic signed [W-1:0]  acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sat_q, sat_d;

    logic signed [W:0]    op;
    logic signed [W+1:0]  sum;

    // Clamp the exact sum into the guarded range.
    function automatic logic signed [W-1:0] clamp(input logic signed [W+1:0] s);
        if (s > MAX_LIM) begin
            return MAX_LIM[W-1:0];
        end else if (s < MIN_LIM) begin
            return MIN_LIM[W-1:0];
        end
        return s[W-1:0];
    endfunction

    // Report whether the exact sum falls outside the guarded range.
    function automatic logic clamp_hit(input logic signed [W+1:0] s);
        return (s > MAX_LIM) || (s < MIN_LIM);
    endfunction

    // Build the operand one bit wider so that negating the most negative sample
    // stays exact. The exact sum is then formed two bits wider than the
    // accumulator.
    always_comb begin
        op  = bus.sub ? -{bus.din[W-1], bus.din} : {bus.din[W-1], bus.din};
        sum = {{2{acc_q[W-1]}}, acc_q} + {op[W], op};
    end

    // Next-state logic. A clear takes priority over any accept or handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (clear) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (bus.in_valid) begin
                        acc_d = clamp(sum);
                        sat_d = sat_q | clamp_hit(sum);
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = CNT_FULL;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    // State registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // in_ready is gated by reset, so the block never advertises space while it
    // is held in reset.
    assign bus.in_ready  = (state_q == ST_ACC) && reset;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.dout      = acc_q;
    assign bus.sat_flag  = sat_q;
    assign bus.count     = cnt_q;
endmodule
